// File: rtl/seg_pkg.sv
// Shared types for the seven-segment scanner:
// segment vector, blank pattern, scan FSM states.
package seg_pkg;

  typedef logic [0:6] seg_t;

  localparam seg_t SEG_BLANK = 7'b1111111;
  localparam seg_t SEG_ZERO  = 7'b0000001;

  typedef enum logic [1:0] {
    OFF,
    GUARD,
    ON
  } state_t;

endpackage

// File: rtl/binaryToBCD.sv
// Hex-digit to active-low segment decoder, index 0 = a.
// Codes above 9 show as "0".
module binaryToBCD
  import seg_pkg::*;
(
  input  logic [3:0] bin,
  output seg_t       seg
);

  always_comb begin
    seg = SEG_ZERO;
    unique case (bin)
      4'd0: seg = 7'b0000001;
      4'd1: seg = 7'b1001111;
      4'd2: seg = 7'b0010010;
      4'd3: seg = 7'b0000110;
      4'd4: seg = 7'b1001100;
      4'd5: seg = 7'b0100100;
      4'd6: seg = 7'b0100000;
      4'd7: seg = 7'b0001111;
      4'd8: seg = 7'b0000000;
      4'd9: seg = 7'b0000100;
      default: seg = SEG_ZERO;
    endcase
  end

endmodule

// File: rtl/seven_seg_scanner.sv
// Round-robin common-anode digit scanner with guard blanking
// and frame-aligned commit of newly loaded display contents.
module seven_seg_scanner
  import seg_pkg::*;
#(
  parameter int N_DIGITS     = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int GUARD_CYCLES = 500
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [4*N_DIGITS-1:0] load_digits,
  input  logic [N_DIGITS-1:0]   load_blank,
  output logic [0:6]            seg,
  output logic [N_DIGITS-1:0]   an,
  output logic                  frame_done
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int DW = $clog2(N_DIGITS);

  localparam logic [CW-1:0] SLOT_LAST  = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] GUARD_LAST =
    CW'((GUARD_CYCLES > 0) ? GUARD_CYCLES - 1 : 0);
  localparam logic [DW-1:0] DIG_LAST   = DW'(N_DIGITS - 1);
  localparam logic [N_DIGITS-1:0] AN_OFF = '1;

  // With no guard interval every slot opens directly in ON.
  localparam state_t SLOT_START = (GUARD_CYCLES > 0) ? GUARD : ON;

  state_t                state_q, state_d;
  logic [CW-1:0]         slot_cnt_q, slot_cnt_d;
  logic [DW-1:0]         digit_idx_q, digit_idx_d;

  logic [4*N_DIGITS-1:0] act_digits_q, act_digits_d;
  logic [N_DIGITS-1:0]   act_blank_q, act_blank_d;
  logic [4*N_DIGITS-1:0] pend_digits_q, pend_digits_d;
  logic [N_DIGITS-1:0]   pend_blank_q, pend_blank_d;
  logic                  pend_full_q, pend_full_d;

  seg_t                  seg_q, seg_d;
  logic [N_DIGITS-1:0]   an_q, an_d;
  logic                  frame_done_q, frame_done_d;

  logic                  frame_end;
  logic                  accept;
  logic [3:0]            sel_digit;
  logic                  sel_blank;
  logic [N_DIGITS-1:0]   sel_onehot;
  logic                  lit;
  seg_t                  dec_seg;

  assign load_ready = ~pend_full_q;
  assign accept     = load_valid & ~pend_full_q;
  assign seg        = seg_q;
  assign an         = an_q;
  assign frame_done = frame_done_q;

  assign frame_end = enable
                   & (state_q == ON)
                   & (digit_idx_q == DIG_LAST)
                   & (slot_cnt_q == SLOT_LAST);

  always_comb begin
    state_d     = state_q;
    slot_cnt_d  = slot_cnt_q;
    digit_idx_d = digit_idx_q;
    if (!enable) begin
      state_d     = OFF;
      slot_cnt_d  = '0;
      digit_idx_d = '0;
    end else begin
      unique case (state_q)
        OFF: begin
          state_d     = SLOT_START;
          slot_cnt_d  = '0;
          digit_idx_d = '0;
        end
        GUARD: begin
          slot_cnt_d = slot_cnt_q + 1'b1;
          if (slot_cnt_q == GUARD_LAST) state_d = ON;
        end
        ON: begin
          if (slot_cnt_q == SLOT_LAST) begin
            state_d     = SLOT_START;
            slot_cnt_d  = '0;
            digit_idx_d = (digit_idx_q == DIG_LAST) ?
                          '0 : digit_idx_q + 1'b1;
          end else begin
            slot_cnt_d = slot_cnt_q + 1'b1;
          end
        end
        default: begin
          state_d     = OFF;
          slot_cnt_d  = '0;
          digit_idx_d = '0;
        end
      endcase
    end
  end

  always_comb begin
    act_digits_d  = act_digits_q;
    act_blank_d   = act_blank_q;
    pend_digits_d = pend_digits_q;
    pend_blank_d  = pend_blank_q;
    pend_full_d   = pend_full_q;
    if (state_q == OFF) begin
      // Nothing on screen to tear: commit straight away.
      if (accept) begin
        act_digits_d = load_digits;
        act_blank_d  = load_blank;
      end else if (pend_full_q) begin
        act_digits_d = pend_digits_q;
        act_blank_d  = pend_blank_q;
        pend_full_d  = 1'b0;
      end
    end else if (frame_end) begin
      if (pend_full_q) begin
        act_digits_d = pend_digits_q;
        act_blank_d  = pend_blank_q;
        pend_full_d  = 1'b0;
      end else if (accept) begin
        act_digits_d = load_digits;
        act_blank_d  = load_blank;
      end
    end else if (accept) begin
      pend_digits_d = load_digits;
      pend_blank_d  = load_blank;
      pend_full_d   = 1'b1;
    end
  end

  always_comb begin
    sel_digit  = '0;
    sel_blank  = 1'b1;
    sel_onehot = '0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (DW'(i) == digit_idx_q) begin
        sel_digit     = act_digits_q[4*i +: 4];
        sel_blank     = act_blank_q[i];
        sel_onehot[i] = 1'b1;
      end
    end
  end

  binaryToBCD u_dec (
    .bin (sel_digit),
    .seg (dec_seg)
  );

  always_comb begin
    lit          = enable & (state_q == ON) & ~sel_blank;
    seg_d        = lit ? dec_seg : SEG_BLANK;
    an_d         = lit ? ~sel_onehot : AN_OFF;
    frame_done_d = frame_end;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= SLOT_START;
      slot_cnt_q    <= '0;
      digit_idx_q   <= '0;
      act_digits_q  <= '0;
      act_blank_q   <= '1;
      pend_digits_q <= '0;
      pend_blank_q  <= '0;
      pend_full_q   <= 1'b0;
      seg_q         <= SEG_BLANK;
      an_q          <= AN_OFF;
      frame_done_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      slot_cnt_q    <= slot_cnt_d;
      digit_idx_q   <= digit_idx_d;
      act_digits_q  <= act_digits_d;
      act_blank_q   <= act_blank_d;
      pend_digits_q <= pend_digits_d;
      pend_blank_q  <= pend_blank_d;
      pend_full_q   <= pend_full_d;
      seg_q         <= seg_d;
      an_q          <= an_d;
      frame_done_q  <= frame_done_d;
    end
  end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed plus random bench for seven_seg_scanner,
// checked every cycle against a phase-arithmetic model.
module tb_seven_seg_scanner;

  localparam int N  = 4;
  localparam int R  = 8;
  localparam int G  = 2;
  localparam int FR = N * R;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        load_valid;
  logic        load_ready;
  logic [15:0] load_digits;
  logic [3:0]  load_blank;
  logic [0:6]  seg;
  logic [3:0]  an;
  logic        frame_done;

  always #5 clk = ~clk;

  seven_seg_scanner #(
    .N_DIGITS     (N),
    .REFRESH_DIV  (R),
    .GUARD_CYCLES (G)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .load_valid  (load_valid),
    .load_ready  (load_ready),
    .load_digits (load_digits),
    .load_blank  (load_blank),
    .seg         (seg),
    .an          (an),
    .frame_done  (frame_done)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // model: cycles since scan start, plus content registers
  int         phase;
  bit         running;
  logic [15:0] m_dig;
  logic [3:0]  m_blank;
  logic [15:0] p_dig;
  logic [3:0]  p_blank;
  bit          p_full;
  logic [0:6]  e_seg;
  logic [3:0]  e_an;
  logic        e_fd;
  logic        e_ready;

  function automatic logic [0:6] pat(input logic [3:0] v);
    logic [0:6] t [16];
    t = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
          7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
          7'b0000000, 7'b0000100, 7'b0000001, 7'b0000001,
          7'b0000001, 7'b0000001, 7'b0000001, 7'b0000001};
    return t[v];
  endfunction

  task automatic check(input string tag,
                       input logic [15:0] obs,
                       input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    int  d;
    int  ins;
    bit  lit;
    bit  fcond;
    bit  acc;
    if (rst) begin
      phase   = 0;
      running = 1;
      m_dig   = '0;
      m_blank = 4'hF;
      p_full  = 0;
      e_seg   = 7'b1111111;
      e_an    = 4'hF;
      e_fd    = 1'b0;
    end else begin
      d     = phase / R;
      ins   = phase % R;
      lit   = running && enable && ins >= G && !m_blank[d];
      e_seg = lit ? pat(m_dig[4*d +: 4]) : 7'b1111111;
      e_an  = lit ? ~(4'b0001 << d) : 4'hF;
      fcond = running && enable && phase == FR - 1;
      e_fd  = fcond;
      acc   = load_valid && !p_full;
      if (!running) begin
        if (acc) begin
          m_dig = load_digits; m_blank = load_blank;
        end else if (p_full) begin
          m_dig = p_dig; m_blank = p_blank; p_full = 0;
        end
      end else if (fcond) begin
        if (p_full) begin
          m_dig = p_dig; m_blank = p_blank; p_full = 0;
        end else if (acc) begin
          m_dig = load_digits; m_blank = load_blank;
        end
      end else if (acc) begin
        p_dig = load_digits; p_blank = load_blank; p_full = 1;
      end
      if (!enable) begin
        running = 0; phase = 0;
      end else if (!running) begin
        running = 1; phase = 0;
      end else begin
        phase = (phase + 1) % FR;
      end
    end
    e_ready = !p_full;
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    check("seg", 16'(seg), 16'(e_seg));
    check("an", 16'(an), 16'(e_an));
    check("frame_done", 16'(frame_done), 16'(e_fd));
    check("load_ready", 16'(load_ready), 16'(e_ready));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic load(input logic [15:0] dg, input logic [3:0] bl);
    bit done;
    done        = 0;
    load_digits = dg;
    load_blank  = bl;
    load_valid  = 1'b1;
    for (int i = 0; i < 100 && !done; i++) begin
      done = load_ready;
      cyc();
    end
    load_valid = 1'b0;
    if (!done) check("load_timeout", 16'd0, 16'd1);
  endtask

  task automatic wait_an(input logic [3:0] v);
    bit hit;
    hit = 0;
    for (int i = 0; i < 200 && !hit; i++) begin
      cyc();
      hit = (an === v);
    end
    if (!hit) check("wait_an_timeout", 16'(an), 16'(v));
  endtask

  int fd_seen;

  initial begin
    rst = 1'b1; enable = 1'b0; load_valid = 1'b0;
    load_digits = '0; load_blank = '0;
    run(2);
    check("rst_an", 16'(an), 16'hF);
    check("rst_seg", 16'(seg), 16'h7F);
    check("rst_ready", 16'(load_ready), 16'd1);
    rst = 1'b0; enable = 1'b1;

    fd_seen = 0;
    for (int i = 0; i < 3 * FR; i++) begin
      cyc();
      if (frame_done === 1'b1) fd_seen++;
      if (an !== 4'hF) check("dark_an", 16'(an), 16'hF);
    end
    check("fd_count", 16'(fd_seen), 16'd3);

    load(16'h4321, 4'b0000);
    wait_an(4'b1110);
    check("d0_seg", 16'(seg), 16'(7'b1001111));
    wait_an(4'b1101);
    check("d1_seg", 16'(seg), 16'(7'b0010010));

    load(16'h8888, 4'b0000);
    check("ready_low", 16'(load_ready), 16'd0);
    load(16'h5678, 4'b0000);
    wait_an(4'b1110);
    check("d0_eight", 16'(seg), 16'(7'b0000000));
    run(2 * FR);

    while (!(running && phase == FR - 1)) cyc();
    load_digits = 16'h9999; load_blank = 4'b0000;
    load_valid  = 1'b1;
    cyc();
    load_valid = 1'b0;
    check("fd_load_ready", 16'(load_ready), 16'd1);
    wait_an(4'b1110);
    check("fd_load_seg", 16'(seg), 16'(pat(4'd9)));

    load(16'h000A, 4'b0100);
    run(3 * FR);

    run(11);
    enable = 1'b0;
    cyc();
    check("off_an", 16'(an), 16'hF);
    load(16'h1234, 4'b0000);
    run(2);
    check("off_ready", 16'(load_ready), 16'd1);
    enable = 1'b1;
    run(2 * FR);

    run(5);
    load(16'h7777, 4'b0000);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check("rst_ready2", 16'(load_ready), 16'd1);
    run(2 * FR);

    for (int i = 0; i < 1500; i++) begin
      load_valid  = ($urandom_range(0, 7) == 0);
      load_digits = 16'($urandom);
      load_blank  = 4'($urandom);
      if ($urandom_range(0, 199) == 0) enable = 1'b0;
      else if (!enable && $urandom_range(0, 3) == 0) enable = 1'b1;
      rst = ($urandom_range(0, 999) == 0);
      cyc();
    end
    load_valid = 1'b0; rst = 1'b0; enable = 1'b1;
    run(FR);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seven_seg_scanner.md
# seven_seg_scanner

Time-multiplexed controller that shares one 4-bit-to-7-segment decoder across `N_DIGITS` common-anode digits. It scans the digits round-robin with a guard (ghost-blanking) interval between them. New display contents arrive through a valid/ready load port. Contents are committed only at frame boundaries, so a frame never shows a mix of old and new digits. The block sits between the lab datapath (counters, ALU results) and the board's segment and anode pins.

## Interface
- `N_DIGITS`, 4: number of multiplexed digits (≥2).
- `REFRESH_DIV`, 50000: clock cycles per digit slot, guard included.
- `GUARD_CYCLES`, 500: cycles at the start of each slot with all anodes off. Constraint: 0 ≤ GUARD_CYCLES < REFRESH_DIV.
- One clock; reset is synchronous and active-high.
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `enable` in 1: scan enable; low forces the display dark.
- `load_valid` in 1: new display contents offered.
- `load_ready` out 1: pending register empty, load accepted this cycle if valid.
- `load_digits` in 4·N_DIGITS: digit i = bits [4i+3:4i]; digit 0 is rightmost.
- `load_blank` in N_DIGITS: bit i = 1 blanks digit i.
- `seg` out [0:6]: segments a..g, active-low; index 0 = a.
- `an` out N_DIGITS: anode enables, active-low; bit i = digit i.
- `frame_done` out 1: one-cycle pulse on the last cycle of digit N_DIGITS-1's slot.

## Operation
- Registers:
  - `active`: the digits and blank mask being displayed.
  - `pending`: the digits and blank mask waiting for commit, with a `pending_full` flag.
  - `digit_idx`: 0..N_DIGITS-1.
  - `slot_cnt`: 0..REFRESH_DIV-1.
- FSM states: OFF, GUARD, ON.
  - After reset: GUARD, `digit_idx`=0, `slot_cnt`=0.
  - GUARD→ON when `slot_cnt` = GUARD_CYCLES-1. With GUARD_CYCLES=0, GUARD is skipped and slots start in ON.
  - ON→GUARD at `slot_cnt` = REFRESH_DIV-1. `slot_cnt` returns to 0 and `digit_idx` increments, wrapping N_DIGITS-1→0.
  - Any state→OFF when `enable`=0. `digit_idx` and `slot_cnt` are cleared.
  - OFF→GUARD when `enable`=1, restarting at digit 0.
- Output decode:
  - In ON, the selected `active` digit is decoded: 0–9 use the standard patterns, and codes 10–15 display as "0" (0000001).
  - If the digit's blank bit is 1, or the state is GUARD or OFF: `an` = all ones and `seg` = 1111111.
  - Otherwise `an` has only bit `digit_idx` low.
- Load handshake:
  - `load_ready` = ~`pending_full`.
  - When `load_valid`&`load_ready`, inputs are captured into `pending` and `pending_full` is set.
  - At a frame boundary (cycle where `frame_done` is asserted), `pending` is copied to `active` and `pending_full` is cleared.
  - Coincident accept with a frame boundary while pending is empty: data goes straight to `active`, `pending_full` stays 0, and `load_ready` stays 1.
  - In OFF state, an accepted load, or an existing pending entry, commits to `active` on the next cycle. There is no frame to tear.
- Reset values:
  - `active` digits = 0 and blank = all ones, so the display is dark until the first load.
  - `pending_full`=0.
  - `an` = all ones, `seg` = 1111111, `frame_done`=0, `load_ready`=1.
- Reset mid-operation discards pending and active contents.

## Timing
- `seg`, `an`, and `frame_done` are registered: each reflects FSM state and counters with one cycle of latency.
- `load_ready` is registered and falls the cycle after an accept.
- It rises the cycle after the `frame_done` internal condition.
- Frame period = N_DIGITS·REFRESH_DIV cycles. Per slot, the anode is on for REFRESH_DIV-GUARD_CYCLES cycles.
- Committed data first appears in digit 0's ON window of the following frame.

## Structure
- Shared package `seg_pkg`:
  - 7-bit segment typedef.
  - `SEG_BLANK` = 7'b1111111.
  - FSM state enum {OFF, GUARD, ON}.
- Sub-module: one instance of the team's existing hex-digit segment decoder `binaryToBCD` (4-bit in, [0:6] active-low out), fed by the digit mux. The controller owns all sequencing.

## Test plan
Parameters for all scenarios: N_DIGITS=4, REFRESH_DIV=8, GUARD_CYCLES=2.
- Reset, then `enable`=1 with no load → `an`=1111, `seg`=1111111, and `load_ready`=1 for 3 full frames. `frame_done` pulses every 32 cycles.
- Load digits {4,3,2,1} (digit0=1), blank=0000 → after commit: digit0 guard shows `an`=1111 for 2 cycles, then `an`=1110 with `seg`=1001111 for 6 cycles. Digit1 follows with `an`=1101 and `seg`=0010010.
- Mid-frame second load {8,8,8,8}, third load held valid → `load_ready` is 0 until the cycle after `frame_done`. The third load is accepted then. 8888 is shown from the next digit-0 window.
- Load asserted on the `frame_done` cycle with pending empty → `load_ready` never drops, and the new data appears in the next frame.
- Load digit0=4'hA with blank=0100 → digit0 `seg`=0000001. During digit2's slot `an`=1111 throughout.
- Drop `enable` mid-slot → `an`=1111 one cycle later. A load accepted while OFF commits next cycle. Re-enable restarts at digit0 guard. Assert `rst` with pending full → dark display, `load_ready`=1, and the pending data is never shown.
